// File: rtl/irq_controller_if.sv
// Bus bundle between the CPU-side logic and the interrupt controller.
// Signal names match the controller's documented port list.
interface irq_controller_if;
    logic       cpu_en;
    logic [2:0] irq_in;
    logic       enable_we;
    logic [2:0] enable_wdata;
    logic       exceptClear;
    logic       eret_clearSignal;
    logic [2:0] interruptSignal;
    logic [2:0] irq_pending;
    logic [2:0] irq_enable;
    logic       in_service;
    logic [7:0] req_wait_cycles;

    modport master (
        output cpu_en, irq_in, enable_we, enable_wdata, exceptClear, eret_clearSignal,
        input  interruptSignal, irq_pending, irq_enable, in_service, req_wait_cycles
    );

    modport slave (
        input  cpu_en, irq_in, enable_we, enable_wdata, exceptClear, eret_clearSignal,
        output interruptSignal, irq_pending, irq_enable, in_service, req_wait_cycles
    );
endinterface

// File: rtl/irq_controller.sv
// Three-source interrupt controller: synchronizes request lines, latches them
// into a pending register, and hands one fixed-priority grant at a time to the
// CPU (bit 0 highest priority).
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | no grant outstanding; arbitrate among pending & enabled
// REQUEST | grant presented on interruptSignal, waiting for exceptClear
// SERVICE | CPU inside handler; no nesting until eret
module irq_controller #(
    parameter bit LEVEL_MODE = 1'b0
) (
    input logic             clk,
    input logic             rst,
    irq_controller_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQUEST = 2'd1,
        SERVICE = 2'd2
    } state_t;

    state_t     state;
    state_t     stateNext;
    logic [2:0] syncS1;
    logic [2:0] syncS2;
    logic [2:0] syncS2d;
    logic [2:0] setMask;
    logic [2:0] clearMask;
    logic [2:0] pendReg;
    logic [2:0] enableReg;
    logic [2:0] activeReq;
    logic [2:0] lowestReq;
    logic [2:0] grantReg;
    logic [2:0] grantNext;
    logic [7:0] waitReg;
    logic [7:0] waitNext;
    logic       serviceReg;

    assign bus.interruptSignal = grantReg;
    assign bus.irq_pending     = pendReg;
    assign bus.irq_enable      = enableReg;
    assign bus.in_service      = serviceReg;
    assign bus.req_wait_cycles = waitReg;

    // Two-flop synchronizer plus delayed copy for edge detection; never frozen.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            syncS1  <= 3'b000;
            syncS2  <= 3'b000;
            syncS2d <= 3'b000;
        end else begin
            syncS1  <= bus.irq_in;
            syncS2  <= syncS1;
            syncS2d <= syncS2;
        end
    end

    // s2_d resets low, so a line already high at reset release counts as one edge.
    assign setMask   = LEVEL_MODE ? syncS2 : (syncS2 & ~syncS2d);
    assign activeReq = pendReg & enableReg;
    // Isolate the lowest set bit: highest-priority request.
    assign lowestReq = activeReq & (~activeReq + 3'd1);

    // Pending and enable registers; a set on the same edge as a clear wins.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pendReg   <= 3'b000;
            enableReg <= 3'b111;
        end else begin
            pendReg <= (pendReg & ~clearMask) | setMask;
            if (bus.enable_we) begin
                enableReg <= bus.enable_wdata;
            end
        end
    end

    // FSM state, presented grant, wait counter and in-service flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            grantReg   <= 3'b000;
            waitReg    <= 8'd0;
            serviceReg <= 1'b0;
        end else begin
            state      <= stateNext;
            grantReg   <= grantNext;
            waitReg    <= waitNext;
            serviceReg <= (stateNext == SERVICE);
        end
    end

    // Next-state, grant and wait-count logic; everything holds while cpu_en is low.
    always_comb begin
        stateNext = state;
        grantNext = grantReg;
        waitNext  = waitReg;
        clearMask = 3'b000;
        if (bus.cpu_en) begin
            case (state)
                IDLE: begin
                    if (activeReq != 3'b000) begin
                        stateNext = REQUEST;
                        grantNext = lowestReq;
                        waitNext  = 8'd0;
                    end
                end
                REQUEST: begin
                    if (waitReg != 8'hFF) begin
                        waitNext = waitReg + 8'd1;
                    end
                    // Acknowledge takes precedence over a mask withdrawal.
                    if (bus.exceptClear) begin
                        stateNext = SERVICE;
                        grantNext = 3'b000;
                        clearMask = grantReg;
                    end else if ((grantReg & enableReg) == 3'b000) begin
                        stateNext = IDLE;
                        grantNext = 3'b000;
                    end
                end
                SERVICE: begin
                    if (bus.eret_clearSignal) begin
                        stateNext = IDLE;
                    end
                end
                default: begin
                    stateNext = IDLE;
                    grantNext = 3'b000;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_irq_controller.sv
// Bench for irq_controller: a cycle table for the basic handshake and priority
// flows, hand-written multi-cycle sequences, then random traffic compared
// against a rule-level model for both edge and level variants.
module tb_irq_controller;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    irq_controller_if b ();
    irq_controller_if bL ();

    irq_controller #(.LEVEL_MODE(1'b0)) uEdge (.clk(clk), .rst(rst), .bus(b.slave));
    irq_controller #(.LEVEL_MODE(1'b1)) uLevel (.clk(clk), .rst(rst), .bus(bL.slave));

    assign bL.cpu_en           = b.cpu_en;
    assign bL.irq_in           = b.irq_in;
    assign bL.enable_we        = b.enable_we;
    assign bL.enable_wdata     = b.enable_wdata;
    assign bL.exceptClear      = b.exceptClear;
    assign bL.eret_clearSignal = b.eret_clearSignal;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    // Reference model: index 0 = edge-triggered instance, 1 = level-triggered.
    logic [2:0] mPend[2];
    logic [2:0] mEn[2];
    logic [2:0] mHist0[2];
    logic [2:0] mHist1[2];
    logic [2:0] mHist2[2];
    int         mGrant[2];
    bit         mServ[2];
    int         mWait[2];

    task automatic modelReset();
        for (int m = 0; m < 2; m++) begin
            mPend[m]  = 3'b000;
            mEn[m]    = 3'b111;
            mHist0[m] = 3'b000;
            mHist1[m] = 3'b000;
            mHist2[m] = 3'b000;
            mGrant[m] = -1;
            mServ[m]  = 1'b0;
            mWait[m]  = 0;
        end
    endtask

    task automatic modelStep();
        for (int m = 0; m < 2; m++) begin
            logic [2:0] setM;
            logic [2:0] clrM;
            setM = (m == 1) ? mHist1[m] : (mHist1[m] & ~mHist2[m]);
            clrM = 3'b000;
            if (b.cpu_en) begin
                if (mServ[m]) begin
                    if (b.eret_clearSignal) mServ[m] = 1'b0;
                end else if (mGrant[m] >= 0) begin
                    mWait[m] = (mWait[m] < 255) ? mWait[m] + 1 : 255;
                    if (b.exceptClear) begin
                        clrM[mGrant[m]] = 1'b1;
                        mServ[m]  = 1'b1;
                        mGrant[m] = -1;
                    end else if (!mEn[m][mGrant[m]]) begin
                        mGrant[m] = -1;
                    end
                end else begin
                    for (int i = 0; i < 3; i++) begin
                        if (mGrant[m] < 0 && mPend[m][i] && mEn[m][i]) begin
                            mGrant[m] = i;
                            mWait[m]  = 0;
                        end
                    end
                end
            end
            mPend[m] = (mPend[m] & ~clrM) | setM;
            if (b.enable_we) mEn[m] = b.enable_wdata;
            mHist2[m] = mHist1[m];
            mHist1[m] = mHist0[m];
            mHist0[m] = b.irq_in;
        end
    endtask

    task automatic step();
        @(posedge clk);
        modelStep();
        @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic waitInt(input string name, input logic [2:0] want, input int budget);
        int n;
        n = 0;
        while (b.interruptSignal !== want && n < budget) begin
            step();
            n++;
        end
        chk(name, b.interruptSignal, want);
    endtask

    task automatic cmpInst(input int m, input logic [2:0] aInt, input logic [2:0] aPend,
                           input logic [2:0] aEn, input logic aSvc, input logic [7:0] aWait);
        logic [2:0] eInt;
        eInt = (mGrant[m] >= 0) ? (3'b001 << mGrant[m]) : 3'b000;
        chk($sformatf("rnd%0d_int", m), aInt, eInt);
        chk($sformatf("rnd%0d_pend", m), aPend, mPend[m]);
        chk($sformatf("rnd%0d_en", m), aEn, mEn[m]);
        chk($sformatf("rnd%0d_svc", m), aSvc, mServ[m]);
        chk($sformatf("rnd%0d_wait", m), aWait, mWait[m]);
    endtask

    typedef struct {
        logic [2:0] irq;
        logic       ec;
        logic       eret;
        logic [2:0] expInt;
        logic [2:0] expPend;
        logic       expSvc;
        logic [7:0] expWait;
    } vec_t;

    vec_t tbl[20];

    initial begin
        checks = 0;
        errors = 0;
        // Handshake on bit 1, then simultaneous bits 2:1.
        tbl[0]  = '{3'b010, 1'b0, 1'b0, 3'b000, 3'b000, 1'b0, 8'd0};
        tbl[1]  = '{3'b010, 1'b0, 1'b0, 3'b000, 3'b000, 1'b0, 8'd0};
        tbl[2]  = '{3'b010, 1'b0, 1'b0, 3'b000, 3'b010, 1'b0, 8'd0};
        tbl[3]  = '{3'b010, 1'b0, 1'b0, 3'b010, 3'b010, 1'b0, 8'd0};
        tbl[4]  = '{3'b010, 1'b0, 1'b0, 3'b010, 3'b010, 1'b0, 8'd1};
        tbl[5]  = '{3'b010, 1'b0, 1'b1, 3'b010, 3'b010, 1'b0, 8'd2};
        tbl[6]  = '{3'b010, 1'b1, 1'b0, 3'b000, 3'b000, 1'b1, 8'd3};
        tbl[7]  = '{3'b000, 1'b0, 1'b1, 3'b000, 3'b000, 1'b0, 8'd3};
        tbl[8]  = '{3'b000, 1'b0, 1'b0, 3'b000, 3'b000, 1'b0, 8'd3};
        tbl[9]  = '{3'b000, 1'b1, 1'b0, 3'b000, 3'b000, 1'b0, 8'd3};
        tbl[10] = '{3'b110, 1'b0, 1'b0, 3'b000, 3'b000, 1'b0, 8'd3};
        tbl[11] = '{3'b110, 1'b0, 1'b0, 3'b000, 3'b000, 1'b0, 8'd3};
        tbl[12] = '{3'b110, 1'b0, 1'b0, 3'b000, 3'b110, 1'b0, 8'd3};
        tbl[13] = '{3'b110, 1'b0, 1'b0, 3'b010, 3'b110, 1'b0, 8'd0};
        tbl[14] = '{3'b110, 1'b1, 1'b0, 3'b000, 3'b100, 1'b1, 8'd1};
        tbl[15] = '{3'b110, 1'b0, 1'b1, 3'b000, 3'b100, 1'b0, 8'd1};
        tbl[16] = '{3'b110, 1'b0, 1'b0, 3'b100, 3'b100, 1'b0, 8'd0};
        tbl[17] = '{3'b110, 1'b1, 1'b0, 3'b000, 3'b000, 1'b1, 8'd1};
        tbl[18] = '{3'b000, 1'b0, 1'b1, 3'b000, 3'b000, 1'b0, 8'd1};
        tbl[19] = '{3'b000, 1'b0, 1'b0, 3'b000, 3'b000, 1'b0, 8'd1};

        b.cpu_en           = 1'b1;
        b.irq_in           = 3'b000;
        b.enable_we        = 1'b0;
        b.enable_wdata     = 3'b000;
        b.exceptClear      = 1'b0;
        b.eret_clearSignal = 1'b0;
        rst = 1'b1;
        #3 rst = 1'b0;
        modelReset();
        #4;
        chk("rst_int", b.interruptSignal, 3'b000);
        chk("rst_pend", b.irq_pending, 3'b000);
        chk("rst_en", b.irq_enable, 3'b111);
        chk("rst_svc", b.in_service, 1'b0);
        chk("rst_wait", b.req_wait_cycles, 8'd0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 20; i++) begin
            b.irq_in           = tbl[i].irq;
            b.exceptClear      = tbl[i].ec;
            b.eret_clearSignal = tbl[i].eret;
            step();
            chk($sformatf("row%0d_int", i), b.interruptSignal, tbl[i].expInt);
            chk($sformatf("row%0d_pend", i), b.irq_pending, tbl[i].expPend);
            chk($sformatf("row%0d_svc", i), b.in_service, tbl[i].expSvc);
            chk($sformatf("row%0d_wait", i), b.req_wait_cycles, tbl[i].expWait);
        end
        b.exceptClear      = 1'b0;
        b.eret_clearSignal = 1'b0;
        step();

        // Mask withdraw while in REQUEST, then re-enable.
        b.irq_in = 3'b001;
        waitInt("mask_grant", 3'b001, 8);
        b.enable_we = 1'b1;
        b.enable_wdata = 3'b110;
        step();
        b.enable_we = 1'b0;
        chk("mask_en", b.irq_enable, 3'b110);
        chk("mask_int_hold", b.interruptSignal, 3'b001);
        step();
        chk("mask_int_drop", b.interruptSignal, 3'b000);
        chk("mask_pend_kept", b.irq_pending, 3'b001);
        chk("mask_svc", b.in_service, 1'b0);
        step();
        chk("mask_idle", b.interruptSignal, 3'b000);
        b.enable_we = 1'b1;
        b.enable_wdata = 3'b111;
        step();
        b.enable_we = 1'b0;
        chk("mask_reen_wait", b.interruptSignal, 3'b000);
        step();
        chk("mask_regrant", b.interruptSignal, 3'b001);
        b.exceptClear = 1'b1;
        step();
        b.exceptClear = 1'b0;
        chk("mask_ack_pend", b.irq_pending, 3'b000);
        chk("mask_ack_svc", b.in_service, 1'b1);
        b.eret_clearSignal = 1'b1;
        step();
        b.eret_clearSignal = 1'b0;
        b.irq_in = 3'b000;
        repeat (3) step();

        // Freeze, no re-arbitration, saturation.
        b.irq_in = 3'b100;
        waitInt("frz_grant", 3'b100, 8);
        step();
        step();
        chk("frz_wait2", b.req_wait_cycles, 8'd2);
        b.cpu_en = 1'b0;
        b.irq_in = 3'b101;
        repeat (10) step();
        chk("frz_wait_hold", b.req_wait_cycles, 8'd2);
        chk("frz_int_hold", b.interruptSignal, 3'b100);
        chk("frz_pend_capt", b.irq_pending, 3'b101);
        b.cpu_en = 1'b1;
        repeat (300) step();
        chk("sat_wait", b.req_wait_cycles, 8'd255);
        chk("sat_no_rearb", b.interruptSignal, 3'b100);
        b.exceptClear = 1'b1;
        step();
        b.exceptClear = 1'b0;
        chk("sat_ack_pend", b.irq_pending, 3'b001);
        chk("sat_ack_svc", b.in_service, 1'b1);
        b.eret_clearSignal = 1'b1;
        step();
        b.eret_clearSignal = 1'b0;
        chk("sat_eret_svc", b.in_service, 1'b0);
        step();
        chk("sat_next_grant", b.interruptSignal, 3'b001);
        b.exceptClear = 1'b1;
        step();
        b.exceptClear = 1'b0;
        b.eret_clearSignal = 1'b1;
        step();
        b.eret_clearSignal = 1'b0;
        b.irq_in = 3'b000;
        repeat (3) step();

        // Set/clear race on bit 0.
        b.irq_in = 3'b001;
        waitInt("race_grant", 3'b001, 8);
        b.irq_in = 3'b000;
        repeat (3) step();
        b.irq_in = 3'b001;
        repeat (2) step();
        b.exceptClear = 1'b1;
        step();
        b.exceptClear = 1'b0;
        chk("race_pend", b.irq_pending, 3'b001);
        chk("race_svc", b.in_service, 1'b1);
        chk("race_int", b.interruptSignal, 3'b000);
        b.eret_clearSignal = 1'b1;
        step();
        b.eret_clearSignal = 1'b0;
        chk("race_eret", b.in_service, 1'b0);
        step();
        chk("race_regrant", b.interruptSignal, 3'b001);
        b.exceptClear = 1'b1;
        step();
        b.exceptClear = 1'b0;
        b.eret_clearSignal = 1'b1;
        step();
        b.eret_clearSignal = 1'b0;
        b.irq_in = 3'b000;
        repeat (3) step();

        // Async reset mid-SERVICE with the source held high.
        b.irq_in = 3'b010;
        waitInt("ars_grant", 3'b010, 8);
        b.exceptClear = 1'b1;
        step();
        b.exceptClear = 1'b0;
        b.enable_we = 1'b1;
        b.enable_wdata = 3'b011;
        step();
        b.enable_we = 1'b0;
        chk("ars_pre_svc", b.in_service, 1'b1);
        chk("ars_pre_en", b.irq_enable, 3'b011);
        #2 rst = 1'b0;
        modelReset();
        #1;
        chk("ars_int", b.interruptSignal, 3'b000);
        chk("ars_pend", b.irq_pending, 3'b000);
        chk("ars_svc", b.in_service, 1'b0);
        chk("ars_wait", b.req_wait_cycles, 8'd0);
        chk("ars_en", b.irq_enable, 3'b111);
        @(negedge clk);
        rst = 1'b1;
        step();
        step();
        chk("ars_pend_early", b.irq_pending, 3'b000);
        step();
        chk("ars_pend_set", b.irq_pending, 3'b010);
        step();
        chk("ars_int_after", b.interruptSignal, 3'b010);
        b.exceptClear = 1'b1;
        step();
        b.exceptClear = 1'b0;
        repeat (4) step();
        chk("ars_one_set", b.irq_pending, 3'b000);
        b.eret_clearSignal = 1'b1;
        step();
        b.eret_clearSignal = 1'b0;
        b.irq_in = 3'b000;
        repeat (3) step();

        // Async reset mid-REQUEST drops the grant immediately.
        b.irq_in = 3'b010;
        waitInt("arq_grant", 3'b010, 8);
        #2 rst = 1'b0;
        modelReset();
        #1;
        chk("arq_int", b.interruptSignal, 3'b000);
        @(negedge clk);
        rst = 1'b1;
        b.irq_in = 3'b000;
        repeat (3) step();

        // Random traffic on both variants against the model.
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 3) == 0) b.irq_in = 3'($urandom_range(0, 7));
            b.cpu_en           = ($urandom_range(0, 9) != 0);
            b.enable_we        = ($urandom_range(0, 15) == 0);
            b.enable_wdata     = 3'($urandom_range(0, 7));
            b.exceptClear      = ($urandom_range(0, 3) == 0);
            b.eret_clearSignal = ($urandom_range(0, 3) == 0);
            step();
            cmpInst(0, b.interruptSignal, b.irq_pending, b.irq_enable, b.in_service, b.req_wait_cycles);
            cmpInst(1, bL.interruptSignal, bL.irq_pending, bL.irq_enable, bL.in_service, bL.req_wait_cycles);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
